jedro_1_ifu_prefetch: RTL and testbench
=======================================

// Module: jedro_1_ifu_prefetch
// PURPOSE
//  Parametrised prefetching instruction fetch unit. Sits between the instruction ROM and the decoder.
//  Keeps up to FIFO_DEPTH fetched words queued. Serves them over a valid/ready handshake.
//  Supports a configurable memory read latency. On a jump it flushes the queue and kills in-flight reads.
//  Sustains 1 instr/cycle.
// PARAMETERS
//  DATA_WIDTH   32   instruction word width; the PC step is DATA_WIDTH/8
//  ADDR_WIDTH   32   instruction address width
//  FIFO_DEPTH   4    prefetch queue entries; power of two; must be >= MEM_LATENCY+2
//  MEM_LATENCY  1    cycles from imem_en_o to valid imem_rdata_i; range 1..4
//  RESET_PC     0    first fetch address after reset
// PORTS
//  clk_i           in   1           clock; all logic on the rising edge
//  rst_i           in   1           synchronous reset, active-high
//  jmp_instr_i     in   1           redirect fetch this cycle
//  jmp_address_i   in   ADDR_WIDTH  redirect target
//  imem_en_o       out  1           ROM read request
//  imem_addr_o     out  ADDR_WIDTH  ROM read address
//  imem_rdata_i    in   DATA_WIDTH  ROM read data; valid MEM_LATENCY cycles after the request
//  cinstr_o        out  DATA_WIDTH  instruction at the queue head
//  cinstr_addr_o   out  ADDR_WIDTH  address of cinstr_o
//  cinstr_valid_o  out  1           queue head valid
//  cinstr_ready_i  in   1           decoder accepts the head
//  misalign_o      out  1           present only with JEDRO_1_IFU_MISALIGN_CHK_EN
// BEHAVIOUR
//  - Reset (rst_i=1 at a rising edge): state after the edge
//      - pc=RESET_PC; queue empty; in-flight tracker cleared.
//      - cinstr_valid_o=0, imem_en_o=0, imem_addr_o=RESET_PC, cinstr_o=0, cinstr_addr_o=0, misalign_o=0.
//      - Reset mid-operation discards all queued and in-flight words.
//  - Issue
//      - imem_en_o=1 iff !jmp_instr_i && (count + outstanding) < FIFO_DEPTH.
//      - count: queue occupancy. outstanding: in-flight reads. Pops this cycle are not credited.
//      - On issue, pc <= pc + DATA_WIDTH/8, wrapping mod 2**ADDR_WIDTH.
//      - imem_addr_o = pc, combinational.
//  - In-flight tracker: MEM_LATENCY-deep shift register of {valid, addr}.
//      - At its tail, a valid entry pushes {imem_rdata_i, addr} into the queue.
//      - Credit rule guarantees no overflow.
//  - Output
//      - cinstr_o, cinstr_addr_o and cinstr_valid_o reflect the queue head.
//      - Pop when cinstr_valid_o && cinstr_ready_i.
//      - Once valid is asserted, the head is stable until it is popped.
//      - Push and pop in the same cycle are both performed.
//  - Jump (jmp_instr_i=1)
//      - Queue flushed and tracker valids cleared at that edge.
//      - pc <= jmp_address_i; no issue that cycle.
//      - First fetch of the target is on the next cycle.
//      - Target appears on cinstr_o MEM_LATENCY+1 cycles after the jump edge.
//      - Jump with a same-cycle pop: the jump wins; the pop has no extra effect.
//      - Jump with rst_i: reset wins.
//  - Throughput: with cinstr_ready_i held high, 1 instr/cycle after the initial MEM_LATENCY+1 cycles.
//  - Backpressure: with ready low, the queue fills to FIFO_DEPTH and issue stops.
//    The instruction stream resumes with no gaps or duplicates.
// CONFIGURATION
//  JEDRO_1_IFU_MISALIGN_CHK_EN defined:
//   - misalign_o port exists.
//   - A jump with jmp_address_i[1:0]!=0 does the following:
//       - misalign_o=1, registered one cycle after the jump edge.
//       - Queue flushed, fetching halted.
//       - misalign_o held until the next jump with an aligned target, or reset.
//   - Aligned jumps behave normally.
//  JEDRO_1_IFU_MISALIGN_CHK_EN undefined:
//   - Port absent.
//   - Low address bits are forced to 0 on jump (pc <= {jmp_address_i[ADDR_WIDTH-1:2],2'b00}).
// STRUCTURE
//  Package jedro_1_ifu_pkg:
//   - INSTR_BYTES constant.
//   - typedef ifu_entry_t {instr, addr}.
//   - MAX_MEM_LATENCY=4.
//  Sub-module jedro_1_ifu_fifo:
//   - Synchronous FIFO of ifu_entry_t.
//   - push, pop, flush, count, full, empty.
//   - Flush has priority over push.
//  Top:
//   - PC register.
//   - Credit logic.
//   - Latency shift register.
//   - Misalign flag.
// TESTING (ROM word at addr A holds A^32'hA5A5_0000; MEM_LATENCY=1, FIFO_DEPTH=4 unless noted)
//  1 Reset release, ready=1 -> cinstr_valid_o rises 2 cycles after reset deassertion.
//      Addrs then 0,4,8,... back-to-back with data 32'hA5A5_0000,32'hA5A5_0004,...
//  2 ready=0 for 10 cycles after reset -> exactly 4 entries queued; imem_en_o low.
//      Raise ready -> addrs 0,4,8,12,16 consecutively, no gaps or duplicates.
//  3 Jump to 32'h100 while 3 entries are queued and 1 read is in flight -> no stale word is delivered.
//      2 cycles later cinstr_addr_o=32'h100, cinstr_o=32'hA5A5_0100.
//  4 MEM_LATENCY=3, FIFO_DEPTH=8, ready=1 -> first valid 4 cycles after reset, then 1/cycle.
//      Jump to 32'h40 -> 32'h40 valid 4 cycles later.
//  5 rst_i pulsed for 1 cycle mid-stream with ready=1 -> outputs at reset values.
//      The stream restarts at RESET_PC with no old data.
//  6 MISALIGN_CHK_EN: jump to 32'h102 -> misalign_o=1 next cycle, valid stays 0.
//      Then jump to 32'h200 -> misalign_o=0 and 32'h200 is delivered.

Source files
------------

// File: rtl/jedro_1_ifu_pkg.sv
// Shared types and constants for the jedro_1 prefetching instruction fetch unit.
// Optional feature macro used by the top: JEDRO_1_IFU_MISALIGN_CHK_EN.
package jedro_1_ifu_pkg;

  localparam int unsigned INSTR_BYTES     = 4;
  localparam int unsigned IFU_DATA_WIDTH  = INSTR_BYTES * 8;
  localparam int unsigned IFU_ADDR_WIDTH  = 32;
  localparam int unsigned MAX_MEM_LATENCY = 4;

  typedef struct packed {
    logic [IFU_DATA_WIDTH-1:0] instr;
    logic [IFU_ADDR_WIDTH-1:0] addr;
  } ifu_entry_t;

  function automatic logic word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// Synchronous prefetch queue of fetch entries; flush takes priority over push.
// Head entry is read combinationally from the storage at the read pointer.
module jedro_1_ifu_fifo
  import jedro_1_ifu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = ifu_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  entry_t                     data_i,
  output entry_t                     data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign full_o    = (count_r == CNT_W'(DEPTH));
  assign empty_o   = (count_r == {CNT_W{1'b0}});
  assign count_o   = count_r;
  assign data_o    = mem_r[rd_ptr_r];
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  // pointer and occupancy state
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // entry storage, no reset needed since occupancy gates visibility
  always_ff @(posedge clk_i) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/jedro_1_ifu_prefetch.sv
// Prefetching instruction fetch unit: PC, credit-based issue, read-latency tracker, queue.
// Optional JEDRO_1_IFU_MISALIGN_CHK_EN flags misaligned jump targets and halts fetching.
module jedro_1_ifu_prefetch
  import jedro_1_ifu_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           FIFO_DEPTH  = 4,
  parameter int unsigned           MEM_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  jmp_instr_i,
  input  logic [ADDR_WIDTH-1:0] jmp_address_i,
  output logic                  imem_en_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [DATA_WIDTH-1:0] cinstr_o,
  output logic [ADDR_WIDTH-1:0] cinstr_addr_o,
  output logic                  cinstr_valid_o,
  input  logic                  cinstr_ready_i
`ifdef JEDRO_1_IFU_MISALIGN_CHK_EN
  , output logic                misalign_o
`endif
);

  localparam int unsigned PC_STEP = DATA_WIDTH / 8;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OUT_W   = $clog2(MAX_MEM_LATENCY + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] addr;
  } entry_t;

  logic [ADDR_WIDTH-1:0]  pc_r;
  logic [ADDR_WIDTH-1:0]  jump_target_s;
  logic [MEM_LATENCY-1:0] trk_vld_r;
  logic [ADDR_WIDTH-1:0]  trk_addr_r [MEM_LATENCY];
  logic [OUT_W-1:0]       outstanding_s;
  logic [31:0]            credit_sum_s;
  logic                   halt_s;
  logic                   issue_s;
  logic                   push_s;
  logic                   pop_s;
  entry_t                 push_entry_s;
  entry_t                 head_s;
  logic [CNT_W-1:0]       fifo_count_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;

`ifdef JEDRO_1_IFU_MISALIGN_CHK_EN
  logic misalign_r;

  assign jump_target_s = jmp_address_i;
  assign halt_s        = misalign_r;
  assign misalign_o    = misalign_r;

  // sticky misaligned-target flag, re-evaluated on every jump
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misalign_r <= 1'b0;
    end else if (jmp_instr_i) begin
      misalign_r <= !word_aligned(jmp_address_i[1:0]);
    end else begin
      misalign_r <= misalign_r;
    end
  end
`else
  logic unused_low_bits_s;

  assign unused_low_bits_s = ^jmp_address_i[1:0];
  assign jump_target_s     = {jmp_address_i[ADDR_WIDTH-1:2], 2'b00};
  assign halt_s            = 1'b0;
`endif

  // in-flight read count across all tracker stages
  always_comb begin
    outstanding_s = {OUT_W{1'b0}};
    for (int i = 0; i < MEM_LATENCY; i++) begin
      outstanding_s = outstanding_s + OUT_W'(trk_vld_r[i]);
    end
  end

  // Queued plus in-flight words must leave room; a same-cycle pop is deliberately not credited.
  assign credit_sum_s = 32'(fifo_count_s) + 32'(outstanding_s);
  assign issue_s      = !rst_i && !jmp_instr_i && !halt_s && !fifo_full_s
                        && (credit_sum_s < 32'(FIFO_DEPTH));
  assign imem_en_o    = issue_s;
  assign imem_addr_o  = pc_r;

  // program counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_r <= RESET_PC;
    end else if (jmp_instr_i) begin
      pc_r <= jump_target_s;
    end else if (issue_s) begin
      pc_r <= pc_r + ADDR_WIDTH'(PC_STEP);
    end else begin
      pc_r <= pc_r;
    end
  end

  // tracker valid bits; a jump kills every read still in flight
  always_ff @(posedge clk_i) begin
    if (rst_i || jmp_instr_i) begin
      trk_vld_r <= {MEM_LATENCY{1'b0}};
    end else begin
      trk_vld_r[0] <= issue_s;
      for (int i = 1; i < MEM_LATENCY; i++) trk_vld_r[i] <= trk_vld_r[i-1];
    end
  end

  // tracker addresses travel alongside the valid bits
  always_ff @(posedge clk_i) begin
    trk_addr_r[0] <= pc_r;
    for (int i = 1; i < MEM_LATENCY; i++) trk_addr_r[i] <= trk_addr_r[i-1];
  end

  assign push_s       = trk_vld_r[MEM_LATENCY-1];
  assign push_entry_s = '{instr: imem_rdata_i, addr: trk_addr_r[MEM_LATENCY-1]};
  assign pop_s        = !fifo_empty_s && cinstr_ready_i;

  jedro_1_ifu_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (jmp_instr_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (push_entry_s),
    .data_o  (head_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // present the queue head, zeroed while the queue is empty
  always_comb begin
    cinstr_valid_o = !fifo_empty_s;
    if (fifo_empty_s) begin
      cinstr_o      = {DATA_WIDTH{1'b0}};
      cinstr_addr_o = {ADDR_WIDTH{1'b0}};
    end else begin
      cinstr_o      = head_s.instr;
      cinstr_addr_o = head_s.addr;
    end
  end

endmodule

// File: tb/tb_jedro_1_ifu_prefetch.sv
// Directed bench for jedro_1_ifu_prefetch: cycle table on a latency-1/depth-4 instance,
// hand sequences on a latency-3/depth-8 instance and for the misalign option.
module tb_jedro_1_ifu_prefetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance A: MEM_LATENCY=1, FIFO_DEPTH=4
  logic        a_rst = 1'b1, a_jmp = 1'b0, a_ready = 1'b0;
  logic [31:0] a_jaddr = 32'h0;
  logic        a_en, a_valid;
  logic [31:0] a_iaddr, a_rdata, a_instr, a_caddr;
`ifdef JEDRO_1_IFU_MISALIGN_CHK_EN
  logic        a_mis, b_mis;
`endif

  jedro_1_ifu_prefetch #(.MEM_LATENCY(1), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(a_rst), .jmp_instr_i(a_jmp), .jmp_address_i(a_jaddr),
    .imem_en_o(a_en), .imem_addr_o(a_iaddr), .imem_rdata_i(a_rdata),
    .cinstr_o(a_instr), .cinstr_addr_o(a_caddr), .cinstr_valid_o(a_valid),
    .cinstr_ready_i(a_ready)
`ifdef JEDRO_1_IFU_MISALIGN_CHK_EN
    , .misalign_o(a_mis)
`endif
  );

  always @(posedge clk) a_rdata <= a_iaddr ^ K;

  // instance B: MEM_LATENCY=3, FIFO_DEPTH=8
  logic        b_rst = 1'b1, b_jmp = 1'b0, b_ready = 1'b0;
  logic [31:0] b_jaddr = 32'h0;
  logic        b_en, b_valid;
  logic [31:0] b_iaddr, b_instr, b_caddr;
  logic [31:0] b_rom_q [3];

  jedro_1_ifu_prefetch #(.MEM_LATENCY(3), .FIFO_DEPTH(8)) dut_l3 (
    .clk_i(clk), .rst_i(b_rst), .jmp_instr_i(b_jmp), .jmp_address_i(b_jaddr),
    .imem_en_o(b_en), .imem_addr_o(b_iaddr), .imem_rdata_i(b_rom_q[2]),
    .cinstr_o(b_instr), .cinstr_addr_o(b_caddr), .cinstr_valid_o(b_valid),
    .cinstr_ready_i(b_ready)
`ifdef JEDRO_1_IFU_MISALIGN_CHK_EN
    , .misalign_o(b_mis)
`endif
  );

  always @(posedge clk) begin
    b_rom_q[0] <= b_iaddr ^ K;
    b_rom_q[1] <= b_rom_q[0];
    b_rom_q[2] <= b_rom_q[1];
  end

  typedef struct {
    logic        rst;
    logic        jmp;
    logic [31:0] jaddr;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic        exp_en;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic j, input logic [31:0] ja, input logic rdy,
                     input logic v, input logic [31:0] ad, input logic en, input logic [31:0] pc);
    vec_t t;
    t = '{rst: r, jmp: j, jaddr: ja, ready: rdy, exp_valid: v, exp_addr: ad, exp_en: en, exp_pc: pc};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset, then streaming with ready high
    add(1,0,32'h0,1, 0,32'h0,0,32'h0);
    add(0,0,32'h0,1, 0,32'h0,1,32'h4);
    add(0,0,32'h0,1, 1,32'h0,1,32'h8);
    add(0,0,32'h0,1, 1,32'h4,1,32'hC);
    add(0,0,32'h0,1, 1,32'h8,1,32'h10);
    add(0,0,32'h0,1, 1,32'hC,1,32'h14);
    // backpressure: queue fills to four, issue stops, stream resumes gap-free
    add(1,0,32'h0,0, 0,32'h0,0,32'h0);
    add(0,0,32'h0,0, 0,32'h0,1,32'h4);
    add(0,0,32'h0,0, 1,32'h0,1,32'h8);
    add(0,0,32'h0,0, 1,32'h0,1,32'hC);
    add(0,0,32'h0,0, 1,32'h0,0,32'h10);
    for (int i = 0; i < 6; i++) add(0,0,32'h0,0, 1,32'h0,0,32'h10);
    add(0,0,32'h0,1, 1,32'h4,1,32'h10);
    add(0,0,32'h0,1, 1,32'h8,1,32'h14);
    add(0,0,32'h0,1, 1,32'hC,1,32'h18);
    add(0,0,32'h0,1, 1,32'h10,1,32'h1C);
    add(0,0,32'h0,1, 1,32'h14,1,32'h20);
    // jump with three queued and one in flight
    add(1,0,32'h0,0, 0,32'h0,0,32'h0);
    add(0,0,32'h0,0, 0,32'h0,1,32'h4);
    add(0,0,32'h0,0, 1,32'h0,1,32'h8);
    add(0,0,32'h0,0, 1,32'h0,1,32'hC);
    add(0,0,32'h0,0, 1,32'h0,0,32'h10);
    add(0,1,32'h100,0, 0,32'h0,0,32'h100);
    add(0,0,32'h0,1, 0,32'h0,1,32'h104);
    add(0,0,32'h0,1, 1,32'h100,1,32'h108);
    add(0,0,32'h0,1, 1,32'h104,1,32'h10C);
    // jump together with a pop
    add(0,1,32'h20,1, 0,32'h0,0,32'h20);
    add(0,0,32'h0,1, 0,32'h0,1,32'h24);
    add(0,0,32'h0,1, 1,32'h20,1,32'h28);
    add(0,0,32'h0,1, 1,32'h24,1,32'h2C);
    // reset pulse mid-stream
    add(1,0,32'h0,1, 0,32'h0,0,32'h0);
    add(0,0,32'h0,1, 0,32'h0,1,32'h4);
    add(0,0,32'h0,1, 1,32'h0,1,32'h8);
    add(0,0,32'h0,1, 1,32'h4,1,32'hC);
    // reset beats a simultaneous jump
    add(1,1,32'h300,1, 0,32'h0,0,32'h0);
    add(0,0,32'h0,1, 0,32'h0,1,32'h4);
    add(0,0,32'h0,1, 1,32'h0,1,32'h8);

    foreach (vecs[i]) begin
      a_rst = vecs[i].rst; a_jmp = vecs[i].jmp; a_jaddr = vecs[i].jaddr; a_ready = vecs[i].ready;
      tick();
      chk($sformatf("v%0d valid", i), {31'h0, a_valid}, {31'h0, vecs[i].exp_valid});
      chk($sformatf("v%0d imem_en", i), {31'h0, a_en}, {31'h0, vecs[i].exp_en});
      chk($sformatf("v%0d imem_addr", i), a_iaddr, vecs[i].exp_pc);
      if (vecs[i].exp_valid || vecs[i].rst) begin
        chk($sformatf("v%0d cinstr_addr", i), a_caddr, vecs[i].exp_addr);
        chk($sformatf("v%0d cinstr", i), a_instr, vecs[i].exp_valid ? (vecs[i].exp_addr ^ K) : 32'h0);
      end
`ifdef JEDRO_1_IFU_MISALIGN_CHK_EN
      chk($sformatf("v%0d misalign", i), {31'h0, a_mis}, 32'h0);
`endif
    end

`ifdef JEDRO_1_IFU_MISALIGN_CHK_EN
    // misaligned jump halts fetching until an aligned jump
    a_rst = 1'b0; a_jmp = 1'b1; a_jaddr = 32'h102; a_ready = 1'b1;
    tick();
    chk("mis set", {31'h0, a_mis}, 32'h1);
    chk("mis valid", {31'h0, a_valid}, 32'h0);
    a_jmp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mis hold %0d", i), {31'h0, a_mis}, 32'h1);
      chk($sformatf("mis halt valid %0d", i), {31'h0, a_valid}, 32'h0);
      chk($sformatf("mis halt en %0d", i), {31'h0, a_en}, 32'h0);
    end
    a_jmp = 1'b1; a_jaddr = 32'h200;
    tick();
    chk("mis clear", {31'h0, a_mis}, 32'h0);
    a_jmp = 1'b0;
    tick();
    chk("mis recover early", {31'h0, a_valid}, 32'h0);
    tick();
    chk("mis recover valid", {31'h0, a_valid}, 32'h1);
    chk("mis recover addr", a_caddr, 32'h200);
    chk("mis recover instr", a_instr, 32'hA5A5_0200);
`else
    // low target bits are dropped on a jump
    a_rst = 1'b0; a_jmp = 1'b1; a_jaddr = 32'h102; a_ready = 1'b1;
    tick();
    chk("align pc", a_iaddr, 32'h100);
    a_jmp = 1'b0;
    tick();
    tick();
    chk("align valid", {31'h0, a_valid}, 32'h1);
    chk("align addr", a_caddr, 32'h100);
    chk("align instr", a_instr, 32'hA5A5_0100);
`endif

    // latency 3, depth 8: first word four edges after the reset edge, then one per cycle
    b_rst = 1'b1; b_ready = 1'b1;
    tick();
    chk("l3 reset valid", {31'h0, b_valid}, 32'h0);
    chk("l3 reset en", {31'h0, b_en}, 32'h0);
    b_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("l3 fill %0d", i), {31'h0, b_valid}, 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("l3 valid %0d", i), {31'h0, b_valid}, 32'h1);
      chk($sformatf("l3 addr %0d", i), b_caddr, 32'(i * 4));
      chk($sformatf("l3 instr %0d", i), b_instr, 32'(i * 4) ^ K);
    end
    b_jmp = 1'b1; b_jaddr = 32'h40;
    tick();
    chk("l3 jmp flush", {31'h0, b_valid}, 32'h0);
    b_jmp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("l3 jmp wait %0d", i), {31'h0, b_valid}, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("l3 jmp valid %0d", i), {31'h0, b_valid}, 32'h1);
      chk($sformatf("l3 jmp addr %0d", i), b_caddr, 32'h40 + 32'(i * 4));
      chk($sformatf("l3 jmp instr %0d", i), b_instr, (32'h40 + 32'(i * 4)) ^ K);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
